// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl_if
//  Description : Request/response bus between the load/store unit (master)
//                and the data-memory responder (slave).
//                Request channel  : req_valid/req_ready handshake carrying
//                                   is_store, size, signed, addr, wdata, tag.
//                Response channel : resp_valid/resp_ready handshake carrying
//                                   is_store, tag, rdata, err.
//  Revision    : 1.0  initial release
// ============================================================================
interface data_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
);
  // request channel
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_is_store;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [TAG_WIDTH-1:0]  req_tag;

  // response channel
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_is_store;
  logic [TAG_WIDTH-1:0]  resp_tag;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_is_store, req_size, req_signed, req_addr, req_wdata,
           req_tag, resp_ready,
    input  req_ready, resp_valid, resp_is_store, resp_tag, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_is_store, req_size, req_signed, req_addr, req_wdata,
           req_tag, resp_ready,
    output req_ready, resp_valid, resp_is_store, resp_tag, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl
//  Description : In-order data-memory responder. Load/store requests are
//                queued, each is serviced LATENCY cycles after reaching the
//                queue head, and a tagged response (load data, store ack or
//                alignment/size error) is returned in request order.
//  Ports       : clk    - clock
//                reset  - synchronous active-high reset
//                bus    - data_mem_ctrl_if slave (request + response channels)
//                busy   - queue non-empty or request in service
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 5,
  parameter int MEM_WORDS   = 1024,
  parameter int LATENCY     = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  wire            clk,
  input  wire            reset,
  data_mem_ctrl_if.slave bus,
  output logic           busy
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(LATENCY) + 1;
  localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(QUEUE_DEPTH);

  typedef struct packed {
    logic                  is_store;
    logic [1:0]            size;
    logic                  sgn;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [TAG_WIDTH-1:0]  tag;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Request queue
  // --------------------------------------------------------------------------
  req_t             queue_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             push;
  logic             pop;
  req_t             head;

  state_t           state;
  state_t           state_next;
  logic [LAT_W-1:0] lat_cnt;
  logic [LAT_W-1:0] lat_next;
  logic             do_access;

  // Ready depends on the registered count only: a full queue refuses a new
  // request even when the head is popped in the same cycle.
  assign bus.req_ready = (count != CNT_FULL);
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = (state == S_RESP) && bus.resp_ready;
  assign count_next    = count + CNT_W'(push) - CNT_W'(pop);
  assign head          = queue_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      queue_mem[wr_ptr] <= {bus.req_is_store, bus.req_size, bus.req_signed,
                            bus.req_addr, bus.req_wdata, bus.req_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // --------------------------------------------------------------------------
  // Service FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_next;
      lat_cnt <= lat_next;
    end
  end

  always_comb begin
    state_next = state;
    lat_next   = lat_cnt;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          state_next = S_WAIT;
          lat_next   = LAT_INIT;
        end
      end
      S_WAIT: begin
        if (lat_cnt == '0) state_next = S_RESP;
        else               lat_next   = lat_cnt - LAT_W'(1);
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          // A push landing in the same cycle as the pop keeps the queue busy.
          if (count_next != '0) begin
            state_next = S_WAIT;
            lat_next   = LAT_INIT;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The memory access for the head request happens on the WAIT->RESP edge.
  assign do_access = (state == S_WAIT) && (lat_cnt == '0);

  assign busy           = (count != '0) || (state != S_IDLE);
  assign bus.resp_valid = (state == S_RESP);

  // --------------------------------------------------------------------------
  // Head decode: address lane, error detection, load extract, store lanes
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [IDX_W-1:0]      word_idx;
  logic [1:0]            lane;
  logic                  head_err;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_lanes;
  logic [3:0]            store_be;
  logic                  unused_addr_hi;

  // Upper address bits above the word index are deliberately ignored so
  // the address space wraps over the storage.
  assign word_idx       = head.addr[IDX_W+1:2];
  assign lane           = head.addr[1:0];
  assign unused_addr_hi = ^head.addr[ADDR_WIDTH-1:IDX_W+2];

  always_comb begin
    head_err = 1'b0;
    case (head.size)
      2'd1:    head_err = lane[0];
      2'd2:    head_err = (lane != 2'd0);
      2'd3:    head_err = 1'b1;
      default: head_err = 1'b0;
    endcase
  end

  // Aligned accesses only reach here error-free, so one byte-lane shift
  // serves both byte and half extraction.
  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    load_data = rd_word;
    case (head.size)
      2'd0: load_data = head.sgn ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                 : {24'd0, rd_shift[7:0]};
      2'd1: load_data = head.sgn ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                 : {16'd0, rd_shift[15:0]};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    store_lanes = head.wdata;
    store_be    = 4'b0000;
    case (head.size)
      2'd0: begin
        store_lanes = {4{head.wdata[7:0]}};
        store_be    = 4'b0001 << lane;
      end
      2'd1: begin
        store_lanes = {2{head.wdata[15:0]}};
        store_be    = 4'b0011 << lane;
      end
      2'd2: begin
        store_lanes = head.wdata;
        store_be    = 4'b1111;
      end
      default: store_be = 4'b0000;
    endcase
    if (head_err || !head.is_store) store_be = 4'b0000;
  end

  // Storage is not reset; byte-enable write on the access edge.
  always_ff @(posedge clk) begin
    if (!reset && do_access) begin
      for (int b = 0; b < 4; b++) begin
        if (store_be[b]) mem[word_idx][8*b +: 8] <= store_lanes[8*b +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response registers: held stable throughout RESP
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.resp_is_store <= 1'b0;
      bus.resp_tag      <= '0;
      bus.resp_rdata    <= '0;
      bus.resp_err      <= 1'b0;
    end else if (do_access) begin
      bus.resp_is_store <= head.is_store;
      bus.resp_tag      <= head.tag;
      bus.resp_err      <= head_err;
      bus.resp_rdata    <= (head_err || head.is_store) ? '0 : load_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_ctrl
//  Description : Self-checking bench for data_mem_ctrl. Table of requests
//                with hand-derived expected responses feeds a scoreboard
//                queue; hand sequences cover latency, hold, backpressure and
//                mid-flight reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_ctrl;
  localparam int AW = 32, DW = 32, TW = 5, MW = 1024, LAT = 2, QD = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  data_mem_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
    .MEM_WORDS(MW), .LATENCY(LAT), .QUEUE_DEPTH(QD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  typedef struct {
    logic        is_store;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  tag;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [4:0]  tag;
    logic        is_store;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   last_acc = 0;
  vec_t tbl [16];

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic vec_t mk(input logic st, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [4:0] tg, input logic [31:0] er,
                              input logic ee);
    vec_t v;
    v.is_store = st; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd;
    v.tag = tg; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  // Called in the drive phase (just after a rising edge); returns in the
  // drive phase after the accepting edge so requests can go back-to-back.
  task automatic send(input vec_t v);
    exp_t e;
    bit   ok;
    bus.req_valid    = 1'b1;
    bus.req_is_store = v.is_store;
    bus.req_size     = v.size;
    bus.req_signed   = v.sgn;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.req_tag      = v.tag;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      e.tag = v.tag; e.is_store = v.is_store; e.rdata = v.exp_rdata; e.err = v.exp_err;
      sb.push_back(e);
      last_acc = cyc + 1;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !bus.resp_valid) break;
      @(negedge clk);
    end
    chk("drain_empty", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  // Response monitor / scoreboard check
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.resp_valid && bus.resp_ready) begin
      hs_cyc.push_back(cyc + 1);
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_resp: got tag %0d expected no response", bus.resp_tag);
      end else begin
        e = sb.pop_front();
        chk("resp_tag",      32'(bus.resp_tag),   32'(e.tag));
        chk("resp_is_store", 32'(bus.resp_is_store), 32'(e.is_store));
        chk("resp_rdata",    bus.resp_rdata,      e.rdata);
        chk("resp_err",      32'(bus.resp_err),   32'(e.err));
      end
    end
  end

  initial begin
    int   rise_cyc;
    int   seen;
    bit   got;
    vec_t v;

    bus.req_valid = 0; bus.req_is_store = 0; bus.req_size = 0; bus.req_signed = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.req_tag = 0; bus.resp_ready = 1;

    // Backdoor preload
    dut.mem[4]  = 32'h11111111;
    dut.mem[8]  = 32'h8001F0FF;
    dut.mem[12] = 32'hA5A5A5A5;
    dut.mem[16] = 32'h0BADC0DE;
    dut.mem[20] = 32'h13579BDF;

    //          st    sz    sg    addr          wdata          tag    exp_rdata      err
    tbl[0]  = mk(1'b1, 2'd2, 1'b0, 32'h10,       32'hDEADBEEF, 5'd3,  32'h00000000, 1'b0);
    tbl[1]  = mk(1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        5'd4,  32'hDEADBEEF, 1'b0);
    tbl[2]  = mk(1'b0, 2'd0, 1'b1, 32'h20,       32'h0,        5'd5,  32'hFFFFFFFF, 1'b0);
    tbl[3]  = mk(1'b0, 2'd1, 1'b0, 32'h22,       32'h0,        5'd6,  32'h00008001, 1'b0);
    tbl[4]  = mk(1'b0, 2'd0, 1'b1, 32'h21,       32'h0,        5'd7,  32'hFFFFFFF0, 1'b0);
    tbl[5]  = mk(1'b1, 2'd1, 1'b0, 32'h21,       32'h1234,     5'd8,  32'h00000000, 1'b1);
    tbl[6]  = mk(1'b0, 2'd2, 1'b0, 32'h20,       32'h0,        5'd9,  32'h8001F0FF, 1'b0);
    tbl[7]  = mk(1'b1, 2'd0, 1'b0, 32'h33,       32'h77,       5'd10, 32'h00000000, 1'b0);
    tbl[8]  = mk(1'b0, 2'd2, 1'b0, 32'h30,       32'h0,        5'd11, 32'h77A5A5A5, 1'b0);
    tbl[9]  = mk(1'b0, 2'd1, 1'b1, 32'h30,       32'h0,        5'd12, 32'hFFFFA5A5, 1'b0);
    tbl[10] = mk(1'b0, 2'd0, 1'b0, 32'h22,       32'h0,        5'd13, 32'h00000001, 1'b0);
    tbl[11] = mk(1'b0, 2'd3, 1'b0, 32'h10,       32'h0,        5'd14, 32'h00000000, 1'b1);
    tbl[12] = mk(1'b0, 2'd2, 1'b0, 32'h12,       32'h0,        5'd15, 32'h00000000, 1'b1);
    tbl[13] = mk(1'b1, 2'd2, 1'b0, 32'h1010,     32'hCAFEF00D, 5'd16, 32'h00000000, 1'b0);
    tbl[14] = mk(1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        5'd17, 32'hCAFEF00D, 1'b0);
    tbl[15] = mk(1'b0, 2'd1, 1'b1, 32'h12,       32'h0,        5'd18, 32'hFFFFCAFE, 1'b0);

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready",     32'(bus.req_ready),     32'd1);
    chk("rst_resp_valid",    32'(bus.resp_valid),    32'd0);
    chk("rst_busy",          32'(busy),              32'd0);
    chk("rst_resp_tag",      32'(bus.resp_tag),      32'd0);
    chk("rst_resp_rdata",    bus.resp_rdata,         32'd0);
    chk("rst_resp_err",      32'(bus.resp_err),      32'd0);
    chk("rst_resp_is_store", 32'(bus.resp_is_store), 32'd0);
    @(posedge clk); #1;

    // ---------------- table-driven traffic ----------------
    for (int i = 0; i < 16; i++) send(tbl[i]);
    drain();

    // ---------------- single load latency and hold ----------------
    bus.resp_ready = 1'b0;
    send(mk(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 5'd20, 32'h13579BDF, 1'b0));
    got = 1'b0;
    rise_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        got = 1'b1;
        rise_cyc = cyc;
        break;
      end
    end
    chk("lat_resp_seen", 32'(got), 32'd1);
    chk("lat_rise_cycle", rise_cyc, last_acc + LAT + 1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_rdata", bus.resp_rdata, 32'h13579BDF);
      chk("hold_tag",   32'(bus.resp_tag), 32'd20);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    drain();

    // ---------------- backpressure: 5 requests, 4-deep queue ----------------
    bus.resp_ready = 1'b0;
    send(mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd21, 32'hCAFEF00D, 1'b0));
    send(mk(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 5'd22, 32'h8001F0FF, 1'b0));
    send(mk(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 5'd23, 32'h77A5A5A5, 1'b0));
    send(mk(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 5'd24, 32'h13579BDF, 1'b0));
    @(negedge clk);
    chk("full_req_ready", 32'(bus.req_ready), 32'd0);
    chk("full_busy",      32'(busy),          32'd1);
    @(posedge clk); #1;
    hs_cyc.delete();
    bus.resp_ready = 1'b1;
    send(mk(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 5'd25, 32'h000000FF, 1'b0));
    drain();
    chk("bp_resp_count", hs_cyc.size(), 32'd5);
    if (hs_cyc.size() == 5) begin
      for (int i = 1; i < 5; i++) chk("bp_spacing", hs_cyc[i] - hs_cyc[i-1], LAT + 1);
    end

    // ---------------- reset while requests are in flight ----------------
    bus.resp_ready = 1'b0;
    send(mk(1'b1, 2'd2, 1'b0, 32'h40, 32'h55555555, 5'd26, 32'h0, 1'b0));
    send(mk(1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        5'd27, 32'h55555555, 1'b0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("mid_rst_busy",       32'(busy),            32'd0);
    chk("mid_rst_req_ready",  32'(bus.req_ready),   32'd1);
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    chk("no_resp_after_rst", seen, 32'd0);
    @(posedge clk); #1;
    // The discarded store must not have reached memory.
    v = mk(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 5'd28, 32'h0BADC0DE, 1'b0);
    send(v);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
